// File: rtl/decim_scheduler.sv
// ---------------------------------------------------------------------------
// decim_scheduler
// Two-channel sample decimator sharing one output port. Each channel has a
// 1-entry input buffer; a round-robin arbiter grants one full buffer per
// cycle whenever the output register can take a sample. A granted sample is
// either kept (end of a decimation group) or discarded. Decimation factors
// are loaded as pending and take effect per channel only at a group boundary.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   in0_data/valid/ready           channel 0 (mic) sample handshake
//   in1_data/valid/ready           channel 1 (music) sample handshake
//   cfg_factor0/1, cfg_load        requested factors, load pulse
//   cfg_pending[1:0]               per-channel unapplied factor flag
//   out_data/out_ch/valid/ready    kept sample, source channel, handshake
// ---------------------------------------------------------------------------
module decim_scheduler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] in0_data,
   input  logic        in0_valid,
   output logic        in0_ready,
   input  logic [15:0] in1_data,
   input  logic        in1_valid,
   output logic        in1_ready,
   input  logic [3:0]  cfg_factor0,
   input  logic [3:0]  cfg_factor1,
   input  logic        cfg_load,
   output logic [15:0] out_data,
   output logic        out_ch,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  cfg_pending
);

   logic [1:0]  buf_full;
   logic [15:0] buf_data [2];
   logic [3:0]  ph       [2];
   logic [3:0]  act      [2];
   logic [3:0]  pend     [2];
   logic        last_grant;

   logic [15:0] in_data  [2];
   logic [1:0]  in_valid;
   logic        out_free;
   logic        grant_vld;
   logic        grant_ch;
   logic [3:0]  fac_sel;
   logic [3:0]  f_eff;
   logic        keep;

   assign in_data[0] = in0_data;
   assign in_data[1] = in1_data;
   assign in_valid   = {in1_valid, in0_valid};

   // Ready is forced low while reset is held so nothing is accepted then.
   assign in0_ready = rst_n & ~buf_full[0];
   assign in1_ready = rst_n & ~buf_full[1];

   assign out_free = ~out_valid | out_ready;

   always_comb begin
      grant_vld = 1'b0;
      grant_ch  = 1'b0;
      if (out_free) begin
         if (&buf_full) begin
            grant_vld = 1'b1;
            grant_ch  = ~last_grant;
         end else if (buf_full[0]) begin
            grant_vld = 1'b1;
            grant_ch  = 1'b0;
         end else if (buf_full[1]) begin
            grant_vld = 1'b1;
            grant_ch  = 1'b1;
         end
      end
   end

   // A grant landing in the same cycle a pending factor is applied must
   // already use the new factor, otherwise the group would straddle factors.
   always_comb begin
      fac_sel = act[grant_ch];
      if (cfg_pending[grant_ch] && (ph[grant_ch] == 4'd0))
         fac_sel = pend[grant_ch];
   end

   assign f_eff = (fac_sel == 4'd0) ? 4'd1 : fac_sel;
   assign keep  = grant_vld && (ph[grant_ch] == (f_eff - 4'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_full    <= 2'b00;
         cfg_pending <= 2'b00;
         last_grant  <= 1'b1;
         out_valid   <= 1'b0;
         out_data    <= 16'd0;
         out_ch      <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            buf_data[c] <= 16'd0;
            ph[c]       <= 4'd0;
            act[c]      <= 4'd1;
            pend[c]     <= 4'd0;
         end
      end else begin
         // Accept only into an empty buffer; grants only touch full ones.
         for (int c = 0; c < 2; c++) begin
            if (in_valid[c] && !buf_full[c]) begin
               buf_full[c] <= 1'b1;
               buf_data[c] <= in_data[c];
            end
            if (cfg_pending[c] && (ph[c] == 4'd0)) begin
               act[c]         <= pend[c];
               cfg_pending[c] <= 1'b0;
            end
         end

         if (grant_vld) begin
            buf_full[grant_ch] <= 1'b0;
            last_grant         <= grant_ch;
            if (keep)
               ph[grant_ch] <= 4'd0;
            else
               ph[grant_ch] <= ph[grant_ch] + 4'd1;
         end

         if (keep) begin
            out_valid <= 1'b1;
            out_data  <= buf_data[grant_ch];
            out_ch    <= grant_ch;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         // Placed last so a new load wins over the application above; the
         // older pending value is the one copied into act this cycle.
         if (cfg_load) begin
            pend[0]     <= cfg_factor0;
            pend[1]     <= cfg_factor1;
            cfg_pending <= 2'b11;
         end
      end
   end

endmodule

// File: tb/tb_decim_scheduler.sv
module tb_decim_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] in0_data, in1_data;
   logic        in0_valid, in1_valid, in0_ready, in1_ready;
   logic [3:0]  cfg_factor0, cfg_factor1;
   logic        cfg_load;
   logic [15:0] out_data;
   logic        out_ch, out_valid, out_ready;
   logic [1:0]  cfg_pending;

   decim_scheduler dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in0_data    (in0_data),
      .in0_valid   (in0_valid),
      .in0_ready   (in0_ready),
      .in1_data    (in1_data),
      .in1_valid   (in1_valid),
      .in1_ready   (in1_ready),
      .cfg_factor0 (cfg_factor0),
      .cfg_factor1 (cfg_factor1),
      .cfg_load    (cfg_load),
      .out_data    (out_data),
      .out_ch      (out_ch),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .cfg_pending (cfg_pending)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // stimulus queues, scoreboard queues and per-channel reference model
   logic [15:0] tx0[$], tx1[$], exp0[$], exp1[$];
   int  mph[2], mact[2], mpend[2];
   bit  mpending[2];
   int  out_count = 0;
   bit  alt_chk = 0;
   bit  prev_vld = 0;
   logic prev_ch = 1'b0;

   task automatic model_accept(input int c, input logic [15:0] d);
      int f;
      if (mpending[c] && mph[c] == 0) begin
         mact[c]     = mpend[c];
         mpending[c] = 0;
      end
      f = (mact[c] == 0) ? 1 : mact[c];
      if (mph[c] == f - 1) begin
         mph[c] = 0;
         if (c == 0) exp0.push_back(d);
         else        exp1.push_back(d);
      end else begin
         mph[c]++;
      end
   endtask

   // feeders: present the head of each tx queue until accepted
   always @(posedge clk) begin
      #1;
      in0_valid = (tx0.size() > 0);
      if (tx0.size() > 0) in0_data = tx0[0];
      in1_valid = (tx1.size() > 0);
      if (tx1.size() > 0) in1_data = tx1[0];
   end

   // monitor: handshakes observed mid-cycle complete at the next rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         tx0.delete(); tx1.delete(); exp0.delete(); exp1.delete();
         mph = '{0, 0}; mact = '{1, 1}; mpend = '{0, 0}; mpending = '{0, 0};
         prev_vld = 0;
      end else begin
         if (cfg_load) begin
            mpend[0] = cfg_factor0;
            mpend[1] = cfg_factor1;
            mpending = '{1, 1};
         end
         if (in0_valid && in0_ready) begin
            model_accept(0, in0_data);
            void'(tx0.pop_front());
         end
         if (in1_valid && in1_ready) begin
            model_accept(1, in1_data);
            void'(tx1.pop_front());
         end
         if (out_valid && out_ready) begin
            out_count++;
            if (alt_chk && prev_vld) check("alternate", out_ch, !prev_ch);
            prev_ch  = out_ch;
            prev_vld = 1;
            if (out_ch == 1'b0) begin
               if (exp0.size() == 0) check("unexpected_ch0", out_data, 32'hffff_ffff);
               else                  check("data_ch0", out_data, exp0.pop_front());
            end else begin
               if (exp1.size() == 0) check("unexpected_ch1", out_data, 32'hffff_ffff);
               else                  check("data_ch1", out_data, exp1.pop_front());
            end
         end
      end
   end

   task automatic load_cfg(input logic [3:0] f0, input logic [3:0] f1);
      @(posedge clk); #1;
      cfg_factor0 = f0;
      cfg_factor1 = f1;
      cfg_load    = 1'b1;
      @(posedge clk); #1;
      cfg_load    = 1'b0;
      check("cfg_pending_set", cfg_pending, 2'b11);
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk); #2;
         if (tx0.size() == 0 && tx1.size() == 0 && !in0_valid && !in1_valid &&
             in0_ready && in1_ready && !out_valid)
            done = 1;
      end
      check({tag, "_idle"}, done, 1);
      check({tag, "_leftover"}, exp0.size() + exp1.size(), 0);
   endtask

   task automatic wait_out_valid(input string tag);
      bit seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check({tag, "_seen"}, seen, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [15:0] held;

      rst_n = 1'b0; in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0;
      cfg_factor0 = 0; cfg_factor1 = 0; cfg_load = 0; out_ready = 1'b1;
      #22;
      check("rst_in0_ready", in0_ready, 0);
      check("rst_in1_ready", in1_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_pending", cfg_pending, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("rel_in0_ready", in0_ready, 1);
      check("rel_in1_ready", in1_ready, 1);

      // factor 1 both channels, continuous traffic -> strict alternation
      alt_chk = 1; base = out_count;
      for (int i = 0; i < 8; i++) begin
         tx0.push_back(16'h0100 + 16'(i));
         tx1.push_back(16'h0200 + 16'(i));
      end
      wait_idle("pass");
      check("pass_count", out_count - base, 16);
      alt_chk = 0;

      // factor 4 on ch0, samples 1..12 -> 4, 8, 12
      load_cfg(4'd4, 4'd1);
      base = out_count;
      for (int i = 1; i <= 12; i++) tx0.push_back(16'(i));
      wait_idle("dec4");
      check("dec4_count", out_count - base, 3);

      // factor 3 on ch1 with output stalled after the first kept sample
      load_cfg(4'd4, 4'd3);
      base = out_count;
      for (int i = 1; i <= 12; i++) tx1.push_back(16'h0300 + 16'(i));
      wait_out_valid("stall");
      out_ready = 1'b0;
      held = out_data;
      check("stall_first", held, 16'h0303);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("stall_hold", {out_valid, out_ch, out_data}, {1'b1, 1'b1, held});
      end
      check("stall_in1_ready", in1_ready, 0);
      out_ready = 1'b1;
      wait_idle("stall");
      check("stall_count", out_count - base, 4);

      // factor change mid-group on ch0 takes effect at the group boundary
      load_cfg(4'd4, 4'd1);
      base = out_count;
      tx0.push_back(16'h0401); tx0.push_back(16'h0402);
      wait_idle("chg_a");
      load_cfg(4'd2, 4'd1);
      @(posedge clk); @(posedge clk); #1;
      check("chg_pending_ch0", cfg_pending, 2'b01);
      for (int i = 3; i <= 8; i++) tx0.push_back(16'h0400 + 16'(i));
      wait_idle("chg_b");
      check("chg_pending_clr", cfg_pending, 2'b00);
      check("chg_count", out_count - base, 3);

      // factor 0 acts as pass-through
      load_cfg(4'd0, 4'd0);
      base = out_count;
      for (int i = 1; i <= 3; i++) begin
         tx0.push_back(16'h0500 + 16'(i));
         tx1.push_back(16'h0600 + 16'(i));
      end
      wait_idle("f0");
      check("f0_count", out_count - base, 6);

      // reset mid-group with both buffers full and a stalled output
      load_cfg(4'd4, 4'd1);
      tx0.push_back(16'h0701); tx0.push_back(16'h0702);
      wait_idle("mid_a");
      out_ready = 1'b0;
      tx1.push_back(16'h0801);
      wait_out_valid("mid");
      tx0.push_back(16'h0703); tx1.push_back(16'h0802);
      repeat (4) @(posedge clk);
      #2;
      check("mid_full", {in0_ready, in1_ready}, 2'b00);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", {out_valid, out_ch, out_data}, 18'd0);
      check("mid_rst_pending", cfg_pending, 0);
      check("mid_rst_ready", {in0_ready, in1_ready}, 2'b00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      check("mid_rel_ready", {in0_ready, in1_ready}, 2'b11);
      base = out_count;
      tx0.push_back(16'h0055);
      wait_idle("post");
      check("post_count", out_count - base, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decim_scheduler.md
DECIM_SCHEDULER -- requirements
Module: decim_scheduler

Interface
REQ-001 clk  in  1  system clock; all state on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 in0_data  in  16  channel 0 sample (mic).
REQ-004 in0_valid / in0_ready  in / out  1 / 1  channel 0 handshake; transfer when both high.
REQ-005 in1_data  in  16  channel 1 sample (music).
REQ-006 in1_valid / in1_ready  in / out  1 / 1  channel 1 handshake.
REQ-007 cfg_factor0, cfg_factor1  in  4  requested decimation factor per channel.
REQ-008 cfg_load  in  1  single-cycle pulse; captures both cfg_factor values as pending.
REQ-009 out_data  out  16  kept sample.
REQ-010 out_ch  out  1  source channel of out_data.
REQ-011 out_valid / out_ready  out / in  1 / 1  output handshake; transfer when both high.
REQ-012 cfg_pending  out  2  bit c high while channel c has an unapplied factor.

Function
REQ-013 Each channel SHALL have a 1-entry input buffer; inC_ready = buffer empty, and a transfer fills the buffer with the sample.
REQ-014 One grant per cycle SHALL be issued to a full buffer, and only when out_free = !out_valid | out_ready; a grant empties that buffer in the same edge.
REQ-015 Arbitration SHALL be round-robin: with both buffers full, grant the channel not granted last; with one full, grant it; last-grant pointer updates on every grant.
REQ-016 Each channel SHALL have a 4-bit phase counter ph_c and an active factor act_c; effective factor f = max(act_c,1), so 0 and 1 both mean pass-through.
REQ-017 On a grant to channel c: if ph_c == f-1, set ph_c=0 and load out_data, out_ch=c, out_valid=1; otherwise increment ph_c and discard the sample with no output.
REQ-018 Granted discard cycles SHALL still require out_free (uniform grant rule).
REQ-019 out_valid, out_data and out_ch SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 When out_valid & out_ready and no keeping grant occurs that cycle, out_valid SHALL clear next edge; a keeping grant in the same cycle reloads back-to-back with no bubble.
REQ-021 Latency: sample accepted at edge N is granted at earliest edge N+1, giving out_valid=1 after edge N+1; per-channel throughput 1 sample / 2 cycles, aggregate 1 / cycle.
REQ-022 cfg_load SHALL copy cfg_factor0/1 to pend0/pend1 and set cfg_pending=2'b11; a cfg_load while pending overwrites pend values.
REQ-023 Pending factor for channel c SHALL be applied (act_c=pend_c, cfg_pending[c] clears) in any cycle where cfg_pending[c]=1 and ph_c==0.
REQ-024 A grant to channel c in the cycle of application SHALL use pend_c as its factor (no group split across factors).
REQ-025 A simultaneous cfg_load and application SHALL leave the new cfg value pending; the older pending value is applied.
REQ-026 Channels SHALL be fully independent: counters, factors, buffers never interact except through the grant.

Reset
REQ-027 On rst_n low, asynchronously: buffers empty, ph_0=ph_1=0, act_0=act_1=1, pend=0, cfg_pending=0, last-grant=1 (channel 0 first), out_valid=0, out_data=0, out_ch=0.
REQ-028 inC_ready SHALL be 0 while rst_n low and 1 in the first cycle after release.
REQ-029 Reset mid-stream SHALL discard buffered and partial-group samples; no output follows release until a new group completes.

Verification
REQ-030 Factor 1 both channels, both valid every cycle, out_ready=1 -> outputs alternate ch0, ch1, ch0..., each input value appears exactly once, in order per channel.
REQ-031 cfg_factor0=4, load, ch0 only, samples 1..12 -> out_data 4, 8, 12 on ch0; ph_0 wraps 3->0.
REQ-032 Factor 3 on ch1, out_ready held 0 for 10 cycles after first output -> out_data frozen, in1_ready falls after buffer fills, no sample lost after release.
REQ-033 ch0 factor 4, cfg_load factor 2 after 2 samples -> factor applies only after sample 4 completes; subsequent outputs every 2nd sample; cfg_pending[0] clears at ph_0==0.
REQ-034 Factor 0 loaded -> behaves as factor 1 (every sample output).
REQ-035 rst_n asserted with ph_0=2 and both buffers full -> all outputs zero immediately; after release, factor 1 restored, first ch0 output on first sample.
